// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared types for the geometry-to-rasterizer path.
//   vertex_t    : packed vertex {x[15:0], y[15:0], z[7:0], u[31:0], v[31:0]}
//   prim_mode_e : primitive assembly mode (triangle list / triangle strip)
//   VTX_W       : width of a packed vertex
//   XY_W        : width of the {x, y} screen-position field at the top of a vertex
// -----------------------------------------------------------------------------
package raster_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  z;
    logic [31:0] u;
    logic [31:0] v;
  } vertex_t;

  typedef enum logic {
    PRIM_LIST  = 1'b0,
    PRIM_STRIP = 1'b1
  } prim_mode_e;

  localparam int VTX_W = $bits(vertex_t);
  localparam int XY_W  = 32;

endpackage

// File: rtl/tri_vtx_fifo.sv
// -----------------------------------------------------------------------------
// tri_vtx_fifo
// Vertex FIFO feeding the triangle assembler. Pointers carry one extra wrap
// bit so full/empty/level come straight from the registered pointers; the
// write-ready flag is therefore stable for the whole cycle, and a push into a
// full FIFO is refused even when a pop happens on the same edge.
// DEPTH must be a power of 2 and at least 4.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_wr_valid        write strobe
//   i_wr_data [W]     write data
//   o_wr_ready        FIFO not full
//   i_rd_pop          consume the head entry
//   o_rd_data [W]     head entry (combinational read)
//   o_empty           FIFO empty
//   o_level           occupancy, 0..DEPTH
//   o_almost_full     level >= DEPTH-AFULL_MARGIN
//   o_overflow        sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module tri_vtx_fifo #(
  parameter int W            = 104,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_valid,
  input  logic [W-1:0]             i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_rd_pop,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_almost_full,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_TH = (AW+1)'(DEPTH - AFULL_MARGIN);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         r_overflow;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic [AW:0]  w_level;

  // Full when the index bits match but the wrap bits differ.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_level = r_wr_ptr - r_rd_ptr;

  assign w_push = i_wr_valid && !w_full;
  assign w_pop  = i_rd_pop && !w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_wr_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_wr_ready    = !w_full;
  assign o_rd_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty       = w_empty;
  assign o_level       = w_level;
  assign o_almost_full = (w_level >= AFULL_TH);
  assign o_overflow    = r_overflow;

endmodule

// File: rtl/tri_assembly_fifo.sv
// -----------------------------------------------------------------------------
// tri_assembly_fifo
// Buffers packed vertices from the geometry engine and assembles them into
// triangles for the rasterizer, in triangle-list or triangle-strip mode.
// Strip mode alternates the output order of the first two vertices so that
// every emitted triangle keeps the same winding.
//
// Optional build macro: TRI_ASSY_DEGEN_CULL_EN
//   When defined, triangles with any two vertices sharing identical {x, y}
//   are consumed internally (one cycle, no o_tri_valid, strip parity still
//   toggles) and a saturating 16-bit o_cull_cnt port is added.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_mode             0 = list, 1 = strip; latched while slot count is 0
//   i_restart          strip restart: drop partial slots, clear parity
//   i_vtx_valid        vertex write strobe
//   i_vtx_data         packed vertex
//   o_vtx_ready        FIFO not full
//   o_almost_full      FIFO level >= DEPTH-AFULL_MARGIN
//   o_overflow         sticky write-while-full flag
//   o_level            FIFO occupancy
//   o_tri_valid        assembled triangle available
//   o_tri_data         {vA, vB, vC}, vA in the MSBs
//   i_tri_ready        rasterizer accept
//   o_cull_cnt         (macro only) culled-triangle count, saturating
// -----------------------------------------------------------------------------
module tri_assembly_fifo
  import raster_pkg::*;
#(
  parameter int VTX_W        = raster_pkg::VTX_W,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_mode,
  input  logic                     i_restart,
  input  logic                     i_vtx_valid,
  input  logic [VTX_W-1:0]         i_vtx_data,
  output logic                     o_vtx_ready,
  output logic                     o_almost_full,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_tri_valid,
  output logic [3*VTX_W-1:0]       o_tri_data,
`ifdef TRI_ASSY_DEGEN_CULL_EN
  output logic [15:0]              o_cull_cnt,
`endif
  input  logic                     i_tri_ready
);

  logic             w_empty;
  logic [VTX_W-1:0] w_head;
  logic             w_pop;

  tri_vtx_fifo #(
    .W            (VTX_W),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_valid    (i_vtx_valid),
    .i_wr_data     (i_vtx_data),
    .o_wr_ready    (o_vtx_ready),
    .i_rd_pop      (w_pop),
    .o_rd_data     (w_head),
    .o_empty       (w_empty),
    .o_level       (o_level),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow)
  );

  logic [VTX_W-1:0] r_v0;
  logic [VTX_W-1:0] r_v1;
  logic [VTX_W-1:0] r_v2;
  logic [1:0]       r_count;
  logic             r_tri_valid;
  logic             r_parity;
  logic             r_restart_pend;
  prim_mode_e       r_mode;

  logic             w_degen;
  logic             w_tri_valid;
  logic             w_hs;
  logic             w_restart;

`ifdef TRI_ASSY_DEGEN_CULL_EN
  logic [XY_W-1:0] w_xy0;
  logic [XY_W-1:0] w_xy1;
  logic [XY_W-1:0] w_xy2;
  logic [15:0]     r_cull_cnt;

  // {x, y} occupies the top XY_W bits of a packed vertex.
  assign w_xy0 = r_v0[VTX_W-1 -: XY_W];
  assign w_xy1 = r_v1[VTX_W-1 -: XY_W];
  assign w_xy2 = r_v2[VTX_W-1 -: XY_W];

  assign w_degen = r_tri_valid &&
                   ((w_xy0 == w_xy1) || (w_xy0 == w_xy2) || (w_xy1 == w_xy2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cull_cnt <= '0;
    end else if (w_degen && (r_cull_cnt != 16'hFFFF)) begin
      r_cull_cnt <= r_cull_cnt + 16'd1;
    end
  end

  assign o_cull_cnt = r_cull_cnt;
`else
  assign w_degen = 1'b0;
`endif

  // A culled triangle behaves exactly like an accepted one, minus the valid.
  assign w_tri_valid = r_tri_valid && !w_degen;
  assign w_hs        = (w_tri_valid && i_tri_ready) || w_degen;
  assign w_restart   = i_restart || r_restart_pend;

  // No pop while a restart is being applied, so the first vertex after the
  // restart always lands in v0 of a cleared assembler.
  assign w_pop = !w_empty && !w_restart && ((r_count != 2'd3) || w_hs);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v0           <= '0;
      r_v1           <= '0;
      r_v2           <= '0;
      r_count        <= 2'd0;
      r_tri_valid    <= 1'b0;
      r_parity       <= 1'b0;
      r_restart_pend <= 1'b0;
      r_mode         <= PRIM_LIST;
    end else begin
      if (r_count == 2'd0) r_mode <= prim_mode_e'(i_mode);

      if (w_restart && (!r_tri_valid || w_hs)) begin
        // Restart applies now: either nothing is pending, or the pending
        // triangle is leaving on this edge.
        r_count        <= 2'd0;
        r_tri_valid    <= 1'b0;
        r_parity       <= 1'b0;
        r_restart_pend <= 1'b0;
      end else begin
        // Restart requested while a triangle waits: hold it until accepted.
        if (w_restart) r_restart_pend <= 1'b1;

        if (w_hs) begin
          if (r_mode == PRIM_STRIP) begin
            r_v0     <= r_v1;
            r_v1     <= r_v2;
            r_parity <= ~r_parity;
            if (w_pop) begin
              r_v2        <= w_head;
              r_count     <= 2'd3;
              r_tri_valid <= 1'b1;
            end else begin
              r_count     <= 2'd2;
              r_tri_valid <= 1'b0;
            end
          end else begin
            if (w_pop) begin
              r_v0    <= w_head;
              r_count <= 2'd1;
            end else begin
              r_count <= 2'd0;
            end
            r_tri_valid <= 1'b0;
          end
        end else if (w_pop) begin
          case (r_count)
            2'd0:    r_v0 <= w_head;
            2'd1:    r_v1 <= w_head;
            default: r_v2 <= w_head;
          endcase
          r_count     <= r_count + 2'd1;
          r_tri_valid <= (r_count == 2'd2);
        end
      end
    end
  end

  // Odd strip triangles swap their first two vertices to keep the winding.
  assign o_tri_data  = ((r_mode == PRIM_STRIP) && r_parity) ? {r_v1, r_v0, r_v2}
                                                            : {r_v0, r_v1, r_v2};
  assign o_tri_valid = w_tri_valid;

endmodule

// File: doc/tri_assembly_fifo.md
Name: tri_assembly_fifo

Overview:
- Successor to the plain vertex FIFO between the geometry engine and the rasterizer.
- Buffers packed vertices and assembles them into triangles, in either triangle-list or triangle-strip mode; strip mode preserves winding order.
- Adds write-side backpressure, an almost-full flag, a sticky overflow flag, and a valid/ready triangle output bus for the rasterizer.

Parameters:
- VTX_W, 104, packed vertex width {x[15:0], y[15:0], z[7:0], u[31:0], v[31:0]}.
- DEPTH, 64, vertex FIFO depth; must be a power of 2, minimum 4.
- AFULL_MARGIN, 4, o_almost_full asserts when level >= DEPTH-AFULL_MARGIN.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_mode  in  1  primitive mode: 0 = list, 1 = strip. Sampled only when the slot count is 0.
- i_restart  in  1  strip restart pulse; discards partial slots and clears winding parity.
- i_vtx_valid  in  1  vertex write strobe.
- i_vtx_data  in  VTX_W  packed vertex.
- o_vtx_ready  out  1  FIFO not full.
- o_almost_full  out  1  level threshold flag.
- o_overflow  out  1  sticky; set when a write is attempted while full.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_tri_valid  out  1  triangle available.
- o_tri_data  out  3*VTX_W  {vA, vB, vC}, vA in the MSBs.
- i_tri_ready  in  1  rasterizer accept.

Behaviour:
- Reset (async assert, release sync to i_clk):
  - Pointers, level, slot count, parity and mode register clear.
  - o_vtx_ready=1; o_almost_full, o_overflow, o_tri_valid = 0; o_tri_data = 0; o_level = 0.
  - Reset mid-operation drops all buffered vertices and any pending triangle.
- FIFO:
  - Pointers carry one extra wrap bit; full and empty are derived from registered pointers.
  - Write accepted iff i_vtx_valid && o_vtx_ready.
  - A write while full is dropped and sets o_overflow; the flag clears only on reset.
  - Simultaneous push and pop when full: the push is refused, because ready is registered.
  - The head is read combinationally; a pop is a single cycle.
- Slots v0, v1, v2 with count 0..3; o_tri_valid = (count==3), registered.
- Pop rule: pop when FIFO not empty and (count<3 or handshake this cycle).
- Handshake edge (o_tri_valid && i_tri_ready):
  - List mode: count becomes 0, or 1 if a pop happens on the same edge (new v0).
  - Strip mode: v0<=v1, v1<=v2, parity toggles; count becomes 2, or 3 if a pop loads v2 on the same edge.
- Output order:
  - List, or strip with parity=0: {v0, v1, v2}.
  - Strip with parity=1: {v1, v0, v2}.
- o_tri_data and o_tri_valid hold stable until handshake.
- Latency: a vertex written on edge E is popped at E+1. The third vertex of the first triangle produces o_tri_valid high after E+1.
- Throughput: strip mode 1 triangle/cycle sustained; list mode 1 triangle/3 cycles.
- i_restart:
  - With o_tri_valid=0: count=0, parity=0 immediately.
  - With o_tri_valid=1: the pending triangle is held until handshake, then count=0 and parity=0.
  - No pop occurs on the cycle i_restart is asserted.
- Mode is latched when count==0. A change while count>0 is ignored until count next reaches 0.

Optional Feature:
- Macro: TRI_ASSY_DEGEN_CULL_EN.
- Defined: a triangle in which any two vertices have identical {x,y} is consumed internally. It takes one cycle, with no o_tri_valid, and strip parity still toggles. A 16-bit o_cull_cnt output port is added; it saturates at 0xFFFF.
- Undefined: all triangles are emitted; no extra port.

Decomposition:
- Package raster_pkg:
  - vertex_t packed struct (x16, y16, z8, u32, v32);
  - prim_mode_e {PRIM_LIST, PRIM_STRIP};
  - VTX_W localparam = $bits(vertex_t).
- Sub-module tri_vtx_fifo: the parametrised FIFO with level, almost-full and overflow. The assembler stays in the top of this block.

Test Plan:
- List mode: write V0..V5 back-to-back with i_tri_ready=1 -> triangles {V0,V1,V2} then {V3,V4,V5}; the first o_tri_valid is high after the edge following V2's write; then the FIFO is empty and o_level=0.
- Strip mode: write V0..V4 with i_tri_ready=1 -> {V0,V1,V2}, {V2,V1,V3}, {V2,V3,V4} on consecutive cycles.
- Backpressure: DEPTH=8, AFULL_MARGIN=2, i_tri_ready=0, write 12 vertices:
  - o_almost_full rises at level 6; o_vtx_ready=0 at level 8 with 3 vertices in slots;
  - the next write sets o_overflow=1, sticky;
  - after i_tri_ready=1, all 11 accepted vertices drain in order.
- Restart: strip mode, write V0,V1, pulse i_restart, write V2,V3,V4 -> first triangle {V2,V3,V4}, parity 0.
- Reset mid-stream: assert i_rst while o_tri_valid=1 -> o_tri_valid=0, o_level=0 and o_overflow=0 immediately, without waiting for a clock edge.
- TRI_ASSY_DEGEN_CULL_EN: strip V0..V3 with V1.xy==V2.xy -> no o_tri_valid for the first two triangles; o_cull_cnt=2; parity=0 afterwards.
